// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the three requester channels (fetch, data, DMA)
// and the 2-read/1-write RAM port signals shared through the arbiter.
//   f_*   : fetch channel (read only): req, addr -> gnt, rvalid, rdata
//   d_*   : CPU data channel: req, we, addr, wdata -> gnt, rvalid, rdata
//   m_*   : DMA/debug loader channel, same shape as d_*
//   ram_* : RAM side: addr_1 (read), addr_2 (read or write), wdata, we,
//           rdata_1/rdata_2 (registered read data from the RAM)
// Modports:
//   slave  : arbiter view (requests and RAM read data in, grants/RAM controls out)
//   master : environment view (requesters plus RAM instance)
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic [ADDR_W-1:0] ram_addr_1;
  logic [ADDR_W-1:0] ram_addr_2;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata_1;
  logic [DATA_W-1:0] ram_rdata_2;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_req, m_we, m_addr, m_wdata,
    input  ram_rdata_1, ram_rdata_2,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_gnt, m_rvalid, m_rdata,
    output ram_addr_1, ram_addr_2, ram_wdata, ram_we
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata,
    output m_req, m_we, m_addr, m_wdata,
    output ram_rdata_1, ram_rdata_2,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_gnt, m_rvalid, m_rdata,
    input  ram_addr_1, ram_addr_2, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of a 2-read/1-write RAM between fetch (0),
// CPU data (1) and DMA/debug loader (2). Grants and RAM controls are
// combinational from the requests and the rr pointer; read data is routed
// back one cycle after the grant using a registered tag per RAM port.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : ram_arbiter_if.slave (requester channels and RAM port signals)
// ADDR_W/DATA_W must match the interface instance connected to bus.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  logic [2:0]        req_s;
  logic [2:0]        wr_s;
  logic [ADDR_W-1:0] addr_s  [3];
  logic [DATA_W-1:0] wdata_s [3];

  logic [1:0]        rr_r;
  logic [1:0]        rr_next_s;
  logic              tag1_v_r, tag2_v_r;
  logic [1:0]        tag1_idx_r, tag2_idx_r;
  logic              tag1_v_s, tag2_v_s;
  logic [1:0]        tag1_idx_s, tag2_idx_s;

  logic [2:0]        gnt_s;
  logic [ADDR_W-1:0] addr1_s, addr2_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;
  logic              p1_used_s, p2_used_s, wr_gnt_s, first_found_s;
  logic [1:0]        idx_s;

  logic [2:0]        rvalid_s;
  logic [DATA_W-1:0] rdata_s [3];

  // Modular add over the requester ring 0..2 (operands never exceed 2).
  function automatic logic [1:0] ring_add(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Gather the requester channels into index-addressable form; fetch never writes.
  always_comb begin
    req_s      = {bus.m_req, bus.d_req, bus.f_req};
    wr_s       = {bus.m_we, bus.d_we, 1'b0};
    addr_s[0]  = bus.f_addr;
    addr_s[1]  = bus.d_addr;
    addr_s[2]  = bus.m_addr;
    wdata_s[0] = {DATA_W{1'b0}};
    wdata_s[1] = bus.d_wdata;
    wdata_s[2] = bus.m_wdata;
  end

  // Allocation walk rr, rr+1, rr+2 mapping requests onto the two RAM ports.
  always_comb begin
    gnt_s         = 3'b000;
    addr1_s       = {ADDR_W{1'b0}};
    addr2_s       = {ADDR_W{1'b0}};
    ram_wdata_s   = {DATA_W{1'b0}};
    ram_we_s      = 1'b0;
    p1_used_s     = 1'b0;
    p2_used_s     = 1'b0;
    wr_gnt_s      = 1'b0;
    first_found_s = 1'b0;
    idx_s         = 2'd0;
    tag1_v_s      = 1'b0;
    tag1_idx_s    = 2'd0;
    tag2_v_s      = 1'b0;
    tag2_idx_s    = 2'd0;
    rr_next_s     = rr_r;
    for (int k = 0; k < 3; k++) begin
      idx_s = ring_add(rr_r, 2'(k));
      // Reset masks every request so nothing is granted while it is held.
      if (req_s[idx_s] && !reset) begin
        if (!wr_s[idx_s]) begin
          if (!p1_used_s) begin
            gnt_s[idx_s] = 1'b1;
            p1_used_s    = 1'b1;
            addr1_s      = addr_s[idx_s];
            tag1_v_s     = 1'b1;
            tag1_idx_s   = idx_s;
          end else if (!p2_used_s && !wr_gnt_s) begin
            gnt_s[idx_s] = 1'b1;
            p2_used_s    = 1'b1;
            addr2_s      = addr_s[idx_s];
            tag2_v_s     = 1'b1;
            tag2_idx_s   = idx_s;
          end else begin
            gnt_s[idx_s] = 1'b0;
          end
        end else begin
          // A port-2 read taken earlier in the walk blocks this write.
          if (!wr_gnt_s && !p2_used_s) begin
            gnt_s[idx_s] = 1'b1;
            wr_gnt_s     = 1'b1;
            p2_used_s    = 1'b1;
            addr2_s      = addr_s[idx_s];
            ram_wdata_s  = wdata_s[idx_s];
            ram_we_s     = 1'b1;
          end else begin
            gnt_s[idx_s] = 1'b0;
          end
        end
        if (gnt_s[idx_s] && !first_found_s) begin
          first_found_s = 1'b1;
          rr_next_s     = ring_add(idx_s, 2'd1);
        end else begin
          first_found_s = first_found_s;
        end
      end else begin
        gnt_s[idx_s] = 1'b0;
      end
    end
  end

  // rr pointer and per-port read route tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r       <= 2'd0;
      tag1_v_r   <= 1'b0;
      tag1_idx_r <= 2'd0;
      tag2_v_r   <= 1'b0;
      tag2_idx_r <= 2'd0;
    end else begin
      rr_r       <= rr_next_s;
      tag1_v_r   <= tag1_v_s;
      tag1_idx_r <= tag1_idx_s;
      tag2_v_r   <= tag2_v_s;
      tag2_idx_r <= tag2_idx_s;
    end
  end

  // Route the RAM's registered read data to the requester named by the tags.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (tag1_v_r && (tag1_idx_r == 2'(i))) begin
        rvalid_s[i] = 1'b1;
        rdata_s[i]  = bus.ram_rdata_1;
      end else if (tag2_v_r && (tag2_idx_r == 2'(i))) begin
        rvalid_s[i] = 1'b1;
        rdata_s[i]  = bus.ram_rdata_2;
      end else begin
        rvalid_s[i] = 1'b0;
        rdata_s[i]  = {DATA_W{1'b0}};
      end
    end
  end

  assign bus.f_gnt      = gnt_s[0];
  assign bus.d_gnt      = gnt_s[1];
  assign bus.m_gnt      = gnt_s[2];
  assign bus.f_rvalid   = rvalid_s[0];
  assign bus.d_rvalid   = rvalid_s[1];
  assign bus.m_rvalid   = rvalid_s[2];
  assign bus.f_rdata    = rdata_s[0];
  assign bus.d_rdata    = rdata_s[1];
  assign bus.m_rdata    = rdata_s[2];
  assign bus.ram_addr_1 = addr1_s;
  assign bus.ram_addr_2 = addr2_s;
  assign bus.ram_wdata  = ram_wdata_s;
  assign bus.ram_we     = ram_we_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors drive the three requesters against a
// behavioural 2R1W read-before-write RAM. Each vector checks grants and RAM
// controls and pushes expected read returns into a scoreboard queue; a
// negedge monitor pops and compares rvalid/rdata for every requester.
module tb_ram_arbiter;

  logic clk;
  logic reset;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int         due;
    int         who;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         fair_on  = 1'b0;
  int         fair_cnt [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered reads on both ports, write through port 2.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'hA5;
    mem[8'h20] <= 8'h11;
    mem[8'h21] <= 8'h22;
    mem[8'hFF] <= 8'h3C;
  end

  always @(posedge clk) begin
    bus_if.ram_rdata_1 <= mem[bus_if.ram_addr_1];
    bus_if.ram_rdata_2 <= mem[bus_if.ram_addr_2];
    if (bus_if.ram_we) mem[bus_if.ram_addr_2] <= bus_if.ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge, compare each requester's return with the scoreboard.
  initial begin
    logic       exp_v [3];
    logic [7:0] exp_d [3];
    logic       act_v [3];
    logic [7:0] act_d [3];
    exp_t       e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        exp_v[i] = 1'b0;
        exp_d[i] = 8'h00;
      end
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due == cyc) begin
          exp_v[e.who] = 1'b1;
          exp_d[e.who] = e.data;
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL stale_expect: requester %0d due %0d never returned", e.who, e.due);
        end
      end
      act_v[0] = bus_if.f_rvalid; act_d[0] = bus_if.f_rdata;
      act_v[1] = bus_if.d_rvalid; act_d[1] = bus_if.d_rdata;
      act_v[2] = bus_if.m_rvalid; act_d[2] = bus_if.m_rdata;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rvalid[%0d]", i), {31'd0, act_v[i]}, {31'd0, exp_v[i]});
        chk($sformatf("rdata[%0d]", i), {24'd0, act_d[i]}, {24'd0, exp_d[i]});
      end
    end
  end

  // One cycle: drive after the edge, check combinational outputs, log expectations.
  // eg is the expected grant vector {m, d, f}.
  task automatic vec(input string tag, input logic rst,
                     input logic fr, input logic [7:0] fa,
                     input logic dr, input logic dwe, input logic [7:0] da, input logic [7:0] dwd,
                     input logic mr, input logic mwe, input logic [7:0] ma, input logic [7:0] mwd,
                     input logic [2:0] eg, input logic [7:0] ea1, input logic [7:0] ea2,
                     input logic ewe, input logic [7:0] ewd);
    @(posedge clk);
    #1;
    reset          = rst;
    bus_if.f_req   = fr;  bus_if.f_addr  = fa;
    bus_if.d_req   = dr;  bus_if.d_we    = dwe; bus_if.d_addr = da; bus_if.d_wdata = dwd;
    bus_if.m_req   = mr;  bus_if.m_we    = mwe; bus_if.m_addr = ma; bus_if.m_wdata = mwd;
    #2;
    chk({tag, " gnt"}, {29'd0, bus_if.m_gnt, bus_if.d_gnt, bus_if.f_gnt}, {29'd0, eg});
    chk({tag, " ram_addr_1"}, {24'd0, bus_if.ram_addr_1}, {24'd0, ea1});
    chk({tag, " ram_addr_2"}, {24'd0, bus_if.ram_addr_2}, {24'd0, ea2});
    chk({tag, " ram_we"}, {31'd0, bus_if.ram_we}, {31'd0, ewe});
    chk({tag, " ram_wdata"}, {24'd0, bus_if.ram_wdata}, {24'd0, ewd});
    if (fair_on) begin
      fair_cnt[0] += int'(bus_if.f_gnt);
      fair_cnt[1] += int'(bus_if.d_gnt);
      fair_cnt[2] += int'(bus_if.m_gnt);
    end
    // Reads see pre-write contents, so queue reads before applying writes.
    if (eg[0])         sb_q.push_back('{due: cyc + 1, who: 0, data: ref_mem[fa]});
    if (eg[1] && !dwe) sb_q.push_back('{due: cyc + 1, who: 1, data: ref_mem[da]});
    if (eg[2] && !mwe) sb_q.push_back('{due: cyc + 1, who: 2, data: ref_mem[ma]});
    if (eg[1] && dwe)  ref_mem[da] = dwd;
    if (eg[2] && mwe)  ref_mem[ma] = mwd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.f_req = 1'b0; bus_if.f_addr = 8'h00;
    bus_if.d_req = 1'b0; bus_if.d_we = 1'b0; bus_if.d_addr = 8'h00; bus_if.d_wdata = 8'h00;
    bus_if.m_req = 1'b0; bus_if.m_we = 1'b0; bus_if.m_addr = 8'h00; bus_if.m_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h10] = 8'hA5;
    ref_mem[8'h20] = 8'h11;
    ref_mem[8'h21] = 8'h22;
    ref_mem[8'hFF] = 8'h3C;
    for (int i = 0; i < 3; i++) fair_cnt[i] = 0;

    // Held in reset with all three requesting: nothing granted.
    vec("rst_a", 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    vec("rst_b", 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    // Single fetch read, rr 0 -> 1.
    vec("c1",  1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b001, 8'h10, 8'h00, 1'b0, 8'h00);
    // Dual read: d on port 1, m on port 2; rr 1 -> 2.
    vec("c2",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b110, 8'h20, 8'h21, 1'b0, 8'h00);
    // Address 255; rr 2 -> 1.
    vec("c3",  1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b001, 8'hFF, 8'h00, 1'b0, 8'h00);
    // Write plus read of the same address: read returns old 0x00; rr 1 -> 2.
    vec("c4",  1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 8'h30, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 3'b011, 8'h30, 8'h30, 1'b1, 8'h5A);
    // Later read of 0x30 returns 0x5A; rr 2 -> 1.
    vec("c5",  1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b001, 8'h30, 8'h00, 1'b0, 8'h00);
    // Move rr to 2.
    vec("c6",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b010, 8'h20, 8'h00, 1'b0, 8'h00);
    // Write collision at rr=2: m wins, d waits; rr -> 0.
    vec("c7",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 1'b1, 8'h41, 8'h88, 3'b100, 8'h00, 8'h41, 1'b1, 8'h88);
    vec("c8",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 3'b010, 8'h00, 8'h40, 1'b1, 8'h77);
    // Read back both writes; rr 2 -> 0.
    vec("c9",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 3'b110, 8'h41, 8'h40, 1'b0, 8'h00);
    // Fairness: all three read continuously for six cycles.
    fair_on = 1'b1;
    for (int r = 0; r < 2; r++) begin
      vec("fair0", 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b011, 8'h10, 8'h20, 1'b0, 8'h00);
      vec("fair1", 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b110, 8'h20, 8'h21, 1'b0, 8'h00);
      vec("fair2", 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b101, 8'h21, 8'h10, 1'b0, 8'h00);
    end
    fair_on = 1'b0;
    chk("fair f count", fair_cnt[0], 32'd4);
    chk("fair d count", fair_cnt[1], 32'd4);
    chk("fair m count", fair_cnt[2], 32'd4);
    // rr=0: write plus read granted, third requester (read) denied; rr -> 1.
    vec("c16", 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h50, 8'h99, 1'b1, 1'b0, 8'h21, 8'h00, 3'b011, 8'h10, 8'h50, 1'b1, 8'h99);
    vec("c17", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b110, 8'h50, 8'h21, 1'b0, 8'h00);
    // rr=2: port-2 read by f blocks d's later write; rr -> 0.
    vec("c18", 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h60, 8'h12, 1'b1, 1'b0, 8'h20, 8'h00, 3'b101, 8'h20, 8'h10, 1'b0, 8'h00);
    vec("c19", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 3'b010, 8'h00, 8'h60, 1'b1, 8'h12);
    // Read granted, then reset asserted before the next edge: return dropped.
    vec("c20", 1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b001, 8'h60, 8'h00, 1'b0, 8'h00);
    #1;
    reset = 1'b1;
    sb_q.delete();
    vec("c21", 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 8'h55, 1'b1, 1'b0, 8'h21, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    vec("c22", 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    // After reset rr=0: f and d win.
    vec("c23", 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 3'b011, 8'h10, 8'h20, 1'b0, 8'h00);
    // rr=1: lone fetch still granted; reads back the write from c19.
    vec("c24", 1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b001, 8'h60, 8'h00, 1'b0, 8'h00);
    vec("idle1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    vec("idle2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #7;
    chk("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the 2-read/1-write 256x8 data RAM between three requesters: instruction fetch (read-only), CPU data access (read/write) and the DMA/debug loader (read/write). Each cycle it maps up to two requests onto the RAM ports under round-robin priority. It routes the registered read data back to the granted requester one cycle later. Sits between the core/loader and the RAM instance.

Parameters:
ADDR_W, 8, address width (256 words)
DATA_W, 8, data width; must match RAM BIT_LINE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch read request
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  DATA_W  fetch read data
d_req / m_req  in  1  data / DMA request
d_we / m_we  in  1  1=write, 0=read
d_addr / m_addr  in  ADDR_W  address
d_wdata / m_wdata  in  DATA_W  write data
d_gnt / m_gnt  out  1  accepted this cycle
d_rvalid / m_rvalid  out  1  read data valid
d_rdata / m_rdata  out  DATA_W  read data
ram_addr_1  out  ADDR_W  RAM port-1 read address
ram_addr_2  out  ADDR_W  RAM port-2 address (read, or write when ram_we=1)
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata_1  in  DATA_W  RAM port-1 registered read data
ram_rdata_2  in  DATA_W  RAM port-2 registered read data

Behaviour:
- Requester indices: fetch=0, data=1, DMA=2. f_req is always a read.
- Requester holds req/we/addr/wdata stable until gnt=1. Request retires on the gnt cycle.
- gnt, ram_addr_*, ram_we and ram_wdata are combinational from the reqs and the rr pointer.
- rr pointer is a 2-bit register, values 0..2; reset value 0.
- Allocation walks the requesters in the order rr, rr+1, rr+2 (mod 3). Each active requester is granted if a resource is free:
  - read: takes port 1 if free; else port 2 if free and no write granted; else denied.
  - write: takes port 2 if no write granted and port 2 not already used for a read; else denied.
- At most 2 grants per cycle: two reads, or one write (port 2) plus one read (port 1).
- A port-2 read granted earlier in the walk blocks a later write in the same cycle (intended; round-robin resolves it).
- rr update: if any grant this cycle, rr <= (index of first granted requester in walk order + 1) mod 3; else rr holds.
- Idle ports:
  - ram_addr_1 = 0 and ram_addr_2 = 0.
  - ram_we = 0 unless a write is granted.
  - ram_wdata = 0 unless a write is granted.
- Read return:
  - A registered route tag per port records {valid, requester index}.
  - The cycle after a read grant, the matching x_rvalid=1 for exactly one cycle, and x_rdata = ram_rdata of the port used.
  - x_rdata is 0 when x_rvalid=0.
- Latency: read grant at cycle N gives rvalid at N+1. Write data is committed at the edge ending the gnt cycle. Writes never assert rvalid.
- Pipelining: a requester may be regranted in the cycle its previous rvalid is high. Back-to-back reads give one rvalid per cycle.
- Same-cycle write and read to the same address: the read returns the OLD contents. This is RAM read-before-write, and the arbiter does not forward.
- Write wins nothing by type; only rr order matters.
- Reset (asynchronous, any time):
  - rr = 0, route tags cleared, all rvalid = 0, all rdata = 0.
  - While reset is high: all gnt = 0, ram_we = 0.
  - In-flight reads are dropped with no rvalid. Requesters must reissue after reset.
- Boundary: address 255 is treated like any other address; there is no wrap logic. All three requesting with rr=0 grants at most two; the third waits and is first in order at most two cycles later.

Test Plan:
- Reset then single read: RAM[0x10]=0xA5, f_req addr 0x10 at cycle 1 -> f_gnt=1 at cycle 1, ram_addr_1=0x10; f_rvalid=1, f_rdata=0xA5 at cycle 2; rr=1.
- Dual read: d_req rd 0x20, m_req rd 0x21 (RAM=0x11,0x22), rr=1 -> both gnt, d uses port 1, m uses port 2; next cycle d_rdata=0x11, m_rdata=0x22.
- Write plus read: rr=1, d_req wr 0x30<=0x5A, f_req rd 0x30 (old 0x00) -> both gnt, ram_we=1, ram_addr_2=0x30; f_rdata=0x00; a later read of 0x30 returns 0x5A.
- Contention fairness: all three continuous reads for 6 cycles -> each requester granted 4 times, no requester waits more than 1 cycle, rr sequence 0,1,2,...
- Write collision: d_req and m_req both writes, rr=2 -> m_gnt=1, d_gnt=0; next cycle d_gnt=1; ram_we high in both cycles.
- Reset mid-read: read granted at cycle N, reset asserted before edge N+1 -> no rvalid, rr=0, ram_we=0, all gnt=0 while reset is high.
